// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit: word widths, the
// instruction fields that decide whether an operand byte follows, and the
// fetch state enumeration.
package cpu_pkg;

    localparam int INST_W = 16;
    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;

    // An instruction carries a trailing data byte only when the one-argument
    // flag is set and the source field selects the data operand.
    localparam int         ONE_ARG_BIT   = 15;
    localparam int         SRC_FIELD_MSB = 10;
    localparam int         SRC_FIELD_LSB = 9;
    localparam logic [1:0] SRC_DATA      = 2'b01;

    typedef enum logic [1:0] {
        FETCH_HI   = 2'd0,
        FETCH_LO   = 2'd1,
        FETCH_DATA = 2'd2,
        VALID      = 2'd3
    } fetch_state_t;

    // True when the assembled instruction word needs a third (operand) byte.
    function automatic logic needs_operand(input logic [INST_W-1:0] word);
        return word[ONE_ARG_BIT] &&
               (word[SRC_FIELD_MSB:SRC_FIELD_LSB] == SRC_DATA);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory port, redirect port and decoder port.
//
// Handshakes: a memory byte transfer completes in any cycle where mem_req
// and mem_ack are both high; an instruction is consumed in any cycle where
// inst_valid and inst_ready are both high. The requester holds its payload
// (mem_addr, or inst/data) stable until that cycle, and the responder may
// hold ack/ready low for any number of cycles.
interface fetch_unit_if;
    import cpu_pkg::*;

    // Program memory (byte reads)
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [BYTE_W-1:0] mem_rdata;

    // Redirect from execute
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;

    // Decoder side
    logic [INST_W-1:0] inst;
    logic [BYTE_W-1:0] data;
    logic              inst_valid;
    logic              inst_ready;

    // Current fetch state, exported for observation
    fetch_state_t      state;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        input  pc_load, pc_target,
        output inst, data, inst_valid,
        input  inst_ready,
        output state
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        output pc_load, pc_target,
        input  inst, data, inst_valid,
        output inst_ready,
        input  state
    );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter of the fetch unit: a redirect load wins over the
// per-byte increment, and the increment wraps naturally at 16 bits.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Load has priority so a redirect discards a byte completing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads a 2- or 3-byte big-endian instruction one
// byte at a time from program memory, then presents it to the decoder until
// it is accepted. A redirect from execute restarts fetching at a new address.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic              running_q;
    logic [INST_W-1:0] inst_q;
    logic [BYTE_W-1:0] data_q;
    logic [ADDR_W-1:0] pc;

    logic              xfer;
    logic              accept;
    logic              cap_hi;
    logic              cap_lo;
    logic              cap_data;
    logic              clr_data;
    logic [INST_W-1:0] lo_word;

    assign xfer    = bus.mem_req && bus.mem_ack;
    assign accept  = bus.inst_valid && bus.inst_ready;
    // Word as it will look once the low byte now on the bus is captured.
    assign lo_word = {inst_q[INST_W-1:BYTE_W], bus.mem_rdata};

    // Address of the next byte; advances on every completed transfer.
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (bus.pc_load),
        .target (bus.pc_target),
        .inc    (xfer),
        .pc     (pc)
    );

    // Keeps mem_req low during reset and until the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
        end else begin
            running_q <= 1'b1;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and byte-capture strobes; a redirect overrides everything.
    always_comb begin
        state_d  = state_q;
        cap_hi   = 1'b0;
        cap_lo   = 1'b0;
        cap_data = 1'b0;
        clr_data = 1'b0;
        if (bus.pc_load) begin
            state_d = FETCH_HI;
        end else begin
            case (state_q)
                FETCH_HI: begin
                    if (xfer) begin
                        cap_hi  = 1'b1;
                        state_d = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (xfer) begin
                        cap_lo = 1'b1;
                        if (needs_operand(lo_word)) begin
                            state_d = FETCH_DATA;
                        end else begin
                            clr_data = 1'b1;
                            state_d  = VALID;
                        end
                    end
                end
                FETCH_DATA: begin
                    if (xfer) begin
                        cap_data = 1'b1;
                        state_d  = VALID;
                    end
                end
                VALID: begin
                    if (accept) begin
                        state_d = FETCH_HI;
                    end
                end
                default: begin
                    state_d = FETCH_HI;
                end
            endcase
        end
    end

    // Instruction and operand holding registers; data is zeroed for 2-byte forms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q <= '0;
            data_q <= '0;
        end else begin
            if (cap_hi) begin
                inst_q[INST_W-1:BYTE_W] <= bus.mem_rdata;
            end
            if (cap_lo) begin
                inst_q[BYTE_W-1:0] <= bus.mem_rdata;
            end
            if (cap_data) begin
                data_q <= bus.mem_rdata;
            end else if (clr_data) begin
                data_q <= '0;
            end
        end
    end

    assign bus.mem_req    = running_q && (state_q != VALID);
    assign bus.mem_addr   = pc;
    assign bus.inst       = inst_q;
    assign bus.data       = data_q;
    assign bus.inst_valid = (state_q == VALID);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a byte-addressed program memory, a responder with
// programmable wait states and backpressure, an instruction-level model that
// predicts every cycle, and a queue of hand-computed instructions.
module tb_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  fetch_unit_if bus ();
  fetch_unit_if bus_w ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  logic [7:0] mem [0:65535];

  assign bus.mem_rdata     = mem[bus.mem_addr];
  assign bus_w.mem_rdata   = mem[bus_w.mem_addr];
  assign bus_w.mem_ack     = 1'b1;
  assign bus_w.inst_ready  = 1'b1;
  assign bus_w.pc_load     = 1'b0;
  assign bus_w.pc_target   = 16'h0000;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int ack_wait = 0;
  int ready_wait = 0;
  logic [23:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int inst_len(input logic [15:0] w);
    return (w[15] && (w[10:9] == 2'b01)) ? 3 : 2;
  endfunction

  // ---------------- responder: memory ack and consumer ready ----------------
  initial begin
    int wcnt;
    int rcnt;
    wcnt = 0;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (wcnt >= ack_wait) begin
        bus.mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
      if (rst || !bus.inst_valid) begin
        bus.inst_ready = 1'b0;
        rcnt = 0;
      end else if (rcnt >= ready_wait) begin
        bus.inst_ready = 1'b1;
      end else begin
        bus.inst_ready = 1'b0;
        rcnt++;
      end
    end
  end

  // ---------------- model + scoreboard compare ----------------
  logic        m_run = 1'b0;
  logic [15:0] m_start = 16'h0000;
  int          m_n = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_inst = '0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    logic [15:0] w;
    logic [15:0] a;
    int          len;
    logic        e_req;
    logic        e_val;
    logic [7:0]  e_data;
    logic [23:0] sb;
    if (rst) begin
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_addr", bus.mem_addr, 16'h0000);
      check("rst_inst", bus.inst, 16'h0000);
      check("rst_data", bus.data, 8'h00);
      check("rst_inst_valid", bus.inst_valid, 0);
      m_run = 1'b0;
      m_start = 16'h0000;
      m_n = 0;
      prev_hold = 1'b0;
    end else begin
      a = m_start + 16'd1;
      w = {mem[m_start], mem[a]};
      len = inst_len(w);
      a = m_start + 16'd2;
      e_data = (len == 3) ? mem[a] : 8'h00;
      e_req = m_run && (m_n < len);
      e_val = m_run && (m_n == len);
      check("model_mem_req", bus.mem_req, e_req);
      check("model_inst_valid", bus.inst_valid, e_val);
      if (e_req) begin
        a = m_start + 16'(m_n);
        check("model_mem_addr", bus.mem_addr, a);
      end
      if (e_val) begin
        check("model_inst", bus.inst, w);
        check("model_data", bus.data, e_data);
        if (prev_hold) begin
          check("hold_inst", bus.inst, prev_inst);
          check("hold_data", bus.data, prev_data);
        end
        if (bus.inst_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_accept", 1, 0);
          end else begin
            sb = exp_q.pop_front();
            check("sb_inst", bus.inst, sb[23:8]);
            check("sb_data", bus.data, sb[7:0]);
          end
        end
      end
      prev_hold = e_val && !bus.inst_ready && !bus.pc_load;
      prev_inst = bus.inst;
      prev_data = bus.data;
      // advance to the next cycle using the inputs sampled at the coming edge
      if (!m_run) begin
        m_run = 1'b1;
        if (bus.pc_load) begin
          m_start = bus.pc_target;
          m_n = 0;
        end
      end else if (bus.pc_load) begin
        m_start = bus.pc_target;
        m_n = 0;
      end else if (e_req && bus.mem_ack) begin
        m_n++;
      end else if (e_val && bus.inst_ready) begin
        m_start = m_start + 16'(len);
        m_n = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_addr(input logic [15:0] addr, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req && bus.mem_addr == addr) && n < budget);
    if (!(bus.mem_req && bus.mem_addr == addr)) begin
      check("timeout_wait_addr", bus.mem_addr, addr);
    end
  endtask

  task automatic wait_accepts(input int want, input int budget);
    int n;
    n = 0;
    while (acc_cnt < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt < want) begin
      check("timeout_accepts", acc_cnt, want);
    end
  endtask

  task automatic load_pc(input logic [15:0] target);
    @(posedge clk);
    #1;
    bus.pc_load = 1'b1;
    bus.pc_target = target;
  endtask

  task automatic release_pc;
    @(posedge clk);
    #1;
    bus.pc_load = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    // 2-byte at 0, 3-byte at 2
    mem[0] = 8'h80; mem[1] = 8'h2A;
    mem[2] = 8'h82; mem[3] = 8'h00; mem[4] = 8'h5C;
    // waits/backpressure: 3-byte, then three 2-byte forms near the operand rule
    mem[5]  = 8'h83; mem[6]  = 8'h11; mem[7] = 8'hA5;
    mem[8]  = 8'h12; mem[9]  = 8'h34;
    mem[10] = 8'h86; mem[11] = 8'h55;
    mem[12] = 8'h02; mem[13] = 8'h77;
    // partial instruction dropped by redirect
    mem[14] = 8'h80; mem[15] = 8'h99;
    mem[16'h1234] = 8'h90; mem[16'h1235] = 8'h0F;
    mem[16'h1236] = 8'h80; mem[16'h1237] = 8'h01;
    mem[16'h3000] = 8'h86; mem[16'h3001] = 8'h01;
    mem[16'h3002] = 8'h82; mem[16'h3003] = 8'h10; mem[16'h3004] = 8'hEE;
    mem[16'h4000] = 8'h83; mem[16'h4001] = 8'h22; mem[16'h4002] = 8'h44;
    // wrap instance: 0xFFFF then 0x0000
    mem[16'hFFFF] = 8'h81;

    exp_q.push_back({16'h802A, 8'h00});
    exp_q.push_back({16'h8200, 8'h5C});
    exp_q.push_back({16'h8311, 8'hA5});
    exp_q.push_back({16'h1234, 8'h00});
    exp_q.push_back({16'h8655, 8'h00});
    exp_q.push_back({16'h0277, 8'h00});
    exp_q.push_back({16'h900F, 8'h00});
    exp_q.push_back({16'h8601, 8'h00});
    exp_q.push_back({16'h8210, 8'hEE});
    exp_q.push_back({16'h802A, 8'h00});

    bus.mem_ack = 1'b0;
    bus.inst_ready = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_target = 16'h0000;
    rst = 1'b1;

    repeat (2) @(negedge clk);
    check("w_rst_addr", bus_w.mem_addr, 16'hFFFF);
    check("w_rst_req", bus_w.mem_req, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // zero-wait 2-byte then 3-byte fetch
    @(negedge clk);
    check("a_req_before_edge", bus.mem_req, 0);
    @(negedge clk);
    check("a_c0_req", bus.mem_req, 1);
    check("a_c0_addr", bus.mem_addr, 16'h0000);
    check("w_c0_addr", bus_w.mem_addr, 16'hFFFF);
    @(negedge clk);
    check("a_c1_addr", bus.mem_addr, 16'h0001);
    check("a_c1_valid", bus.inst_valid, 0);
    check("w_c1_addr", bus_w.mem_addr, 16'h0000);
    @(negedge clk);
    check("a_c2_valid", bus.inst_valid, 1);
    check("a_c2_inst", bus.inst, 16'h802A);
    check("a_c2_data", bus.data, 8'h00);
    check("a_c2_req", bus.mem_req, 0);
    check("w_c2_inst", bus_w.inst, 16'h8180);
    check("w_c2_valid", bus_w.inst_valid, 1);
    @(negedge clk);
    check("a_c3_addr", bus.mem_addr, 16'h0002);
    check("w_next_addr", bus_w.mem_addr, 16'h0001);
    check("w_next_req", bus_w.mem_req, 1);
    @(negedge clk);
    check("b_c4_valid", bus.inst_valid, 0);
    @(negedge clk);
    check("b_c5_valid", bus.inst_valid, 0);
    check("b_c5_addr", bus.mem_addr, 16'h0004);
    @(negedge clk);
    check("b_c6_valid", bus.inst_valid, 1);
    check("b_c6_inst", bus.inst, 16'h8200);
    check("b_c6_data", bus.data, 8'h5C);
    @(negedge clk);
    check("b_c7_addr", bus.mem_addr, 16'h0005);

    // wait states and backpressure
    ack_wait = 3;
    ready_wait = 5;
    wait_accepts(6, 400);

    // redirect while waiting in FETCH_LO
    ready_wait = 0;
    wait_addr(16'h000F, 100);
    load_pc(16'h1234);
    release_pc();
    ack_wait = 0;
    @(negedge clk);
    check("d1_addr", bus.mem_addr, 16'h1234);
    check("d1_valid", bus.inst_valid, 0);

    // redirect coinciding with transfers, asserted on two cycles
    wait_addr(16'h1236, 100);
    load_pc(16'h2000);
    load_pc(16'h3000);
    release_pc();
    @(negedge clk);
    check("d2_addr_last_target", bus.mem_addr, 16'h3000);
    wait_accepts(8, 100);

    // redirect in the same cycle as acceptance
    wait_addr(16'h3004, 100);
    load_pc(16'h4000);
    release_pc();
    @(negedge clk);
    check("e_addr", bus.mem_addr, 16'h4000);
    check("e_req", bus.mem_req, 1);

    // reset during FETCH_DATA
    wait_addr(16'h4001, 50);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("f_req", bus.mem_req, 0);
    check("f_addr", bus.mem_addr, 16'h0000);
    check("f_inst", bus.inst, 16'h0000);
    check("f_data", bus.data, 8'h00);
    check("f_valid", bus.inst_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("f_req_held", bus.mem_req, 0);
    @(negedge clk);
    check("f_refetch_req", bus.mem_req, 1);
    check("f_refetch_addr", bus.mem_addr, 16'h0000);
    wait_accepts(10, 100);

    check("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
